gshare_branch_predictor: RTL and testbench
==========================================

GSHARE_BRANCH_PREDICTOR -- requirements
Module: gshare_branch_predictor

Interface
REQ-001 Parameter PHT_WIDTH, default 10, log2 of PHT entry count (PHT_SIZE = 2^PHT_WIDTH).
REQ-002 Parameter HIST_LEN, default 8, global history length; SHALL be 1..PHT_WIDTH.
REQ-003 Parameter NUM_PORTS, default 2, parallel prediction ports per fetch group (1..4).
REQ-004 Parameter PC_WIDTH, default 32, PC width.
REQ-005 Parameter INIT_STATE, default 2'b01, counter value written by the init sweep.
REQ-006 clk  in  1  clock; reset rst, synchronous, active-high.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 if_valid  in  NUM_PORTS  fetch slot k valid.
REQ-009 if_pc  in  NUM_PORTS x PC_WIDTH  PC of slot k.
REQ-010 if_is_branch  in  NUM_PORTS  slot k is a conditional branch (BTB hit).
REQ-011 if_stall  in  1  fetch group not accepted this cycle.
REQ-012 predict_taken  out  NUM_PORTS  prediction for slot k.
REQ-013 predict_ghr  out  NUM_PORTS x HIST_LEN  history used to index slot k, carried down the pipeline.
REQ-014 exe_valid  in  1  resolved conditional branch this cycle.
REQ-015 exe_taken  in  1  resolved direction.
REQ-016 exe_mispredict  in  1  resolved direction differed from prediction.
REQ-017 exe_pc  in  PC_WIDTH  PC of resolved branch.
REQ-018 exe_ghr  in  HIST_LEN  predict_ghr snapshot of resolved branch.
REQ-019 init_busy  out  1  PHT init sweep in progress.

Function
REQ-020 PHT SHALL hold PHT_SIZE 2-bit saturating counters; bit[1] set = predict taken.
REQ-021 Index SHALL be pc[PHT_WIDTH+1:2] XOR zero-extended history (history in LSBs).
REQ-022 Slot-k history h_k SHALL be spec_ghr shifted left by one bit, inserting predict_taken, for every lower slot j<k with if_valid&if_is_branch; predict_ghr[k]=h_k.
REQ-023 predict_taken[k] SHALL be counter[1] at index(if_pc[k], h_k) when if_valid[k]&if_is_branch[k], else 0; combinational, same cycle.
REQ-024 Slots after the first slot predicted taken SHALL be squashed: predict_taken 0, no history contribution.
REQ-025 When if_stall=0, spec_ghr SHALL advance at posedge by all non-squashed branch slots of the group (0..NUM_PORTS shifts); when if_stall=1 it SHALL hold.
REQ-026 exe_valid&exe_mispredict SHALL set spec_ghr <= {exe_ghr[HIST_LEN-2:0], exe_taken} at the next posedge, overriding any fetch-side advance that cycle.
REQ-027 exe_valid SHALL update counter at index(exe_pc, exe_ghr) at the next posedge: taken -> +1 saturating at 11; not taken -> -1 saturating at 00.
REQ-028 Update SHALL be visible to predictions in the cycle after exe_valid; same-cycle prediction reads old value.
REQ-029 One update per cycle; exe_mispredict without exe_valid SHALL be ignored.

Reset
REQ-030 rst SHALL clear spec_ghr to 0, set init_busy=1 and reset sweep counter to 0.
REQ-031 Sweep SHALL write INIT_STATE to one entry per cycle, entries 0..PHT_SIZE-1; init_busy SHALL fall in the cycle after the last write (exactly PHT_SIZE busy cycles after rst deasserts).
REQ-032 While init_busy: predict_taken=0, spec_ghr held at 0, exe updates and restores dropped.
REQ-033 rst asserted mid-sweep SHALL restart the sweep from entry 0.

Verification
REQ-034 rst 1 cycle, release -> init_busy=1 for exactly 1024 cycles, predict_taken=0 throughout, exe_valid pulses during sweep leave counters at 01.
REQ-035 After init, exe_valid taken pc=0x100 ghr=0 -> next cycle slot0 pc=0x100 with spec_ghr=0 predicts 1; second taken update -> counter 11; three not-taken -> 00; fourth not-taken stays 00.
REQ-036 spec_ghr=0x03, slot0 branch predicted NT, slot1 branch, if_stall=0 -> predict_ghr[1]=0x06, spec_ghr becomes 0x0C (0x0D if slot1 predicted taken).
REQ-037 Slot0 predicted taken, slot1 valid branch -> predict_taken[1]=0, spec_ghr shifts by one only.
REQ-038 exe_valid&exe_mispredict exe_ghr=0x5A exe_taken=1 with a fetch group accepted same cycle -> spec_ghr=0xB5 next cycle.
REQ-039 if_stall=1 for 5 cycles with branch slots valid -> spec_ghr unchanged.

Source files
------------

// File: rtl/gshare_branch_predictor_if.sv
// Fetch-side prediction and execute-side resolution signals of the gshare predictor.
// The master drives fetch groups and resolved branches; the slave is the predictor itself.
interface gshare_branch_predictor_if #(
    parameter int NUM_PORTS = 2,
    parameter int PC_WIDTH  = 32,
    parameter int HIST_LEN  = 8
);
    logic [NUM_PORTS-1:0]                if_valid;
    logic [NUM_PORTS-1:0][PC_WIDTH-1:0]  if_pc;
    logic [NUM_PORTS-1:0]                if_is_branch;
    logic                                if_stall;
    logic [NUM_PORTS-1:0]                predict_taken;
    logic [NUM_PORTS-1:0][HIST_LEN-1:0]  predict_ghr;
    logic                                exe_valid;
    logic                                exe_taken;
    logic                                exe_mispredict;
    logic [PC_WIDTH-1:0]                 exe_pc;
    logic [HIST_LEN-1:0]                 exe_ghr;
    logic                                init_busy;

    modport master (
        output if_valid, if_pc, if_is_branch, if_stall,
        output exe_valid, exe_taken, exe_mispredict, exe_pc, exe_ghr,
        input  predict_taken, predict_ghr, init_busy
    );

    modport slave (
        input  if_valid, if_pc, if_is_branch, if_stall,
        input  exe_valid, exe_taken, exe_mispredict, exe_pc, exe_ghr,
        output predict_taken, predict_ghr, init_busy
    );
endinterface

// File: rtl/gshare_branch_predictor.sv
// Multi-port gshare direction predictor: PHT of 2-bit counters indexed by PC xor speculative
// global history, with a post-reset sweep that initialises every counter.
module gshare_branch_predictor #(
    parameter int         PHT_WIDTH  = 10,
    parameter int         HIST_LEN   = 8,
    parameter int         NUM_PORTS  = 2,
    parameter int         PC_WIDTH   = 32,
    parameter logic [1:0] INIT_STATE = 2'b01
) (
    input  logic                     clk,
    input  logic                     rst,
    gshare_branch_predictor_if.slave bp
);

    localparam int PHT_SIZE = 1 << PHT_WIDTH;

    typedef enum logic {
        ST_SWEEP,
        ST_RUN
    } state_e;

    state_e                              state;
    state_e                              state_next;
    logic [PHT_WIDTH-1:0]                sweep_idx;
    logic                                init_busy;

    logic [1:0]                          pht [PHT_SIZE];
    logic                                pht_we;
    logic [PHT_WIDTH-1:0]                pht_waddr;
    logic [1:0]                          pht_wdata;

    logic [HIST_LEN-1:0]                 spec_ghr;
    logic [HIST_LEN-1:0]                 spec_ghr_next;
    logic [HIST_LEN-1:0]                 fetch_ghr;
    logic [HIST_LEN-1:0]                 hist;
    logic                                squash;
    logic                                pred_bit;
    logic [NUM_PORTS-1:0]                taken_vec;
    logic [NUM_PORTS-1:0][HIST_LEN-1:0]  ghr_vec;

    logic [PHT_WIDTH-1:0]                exe_idx;
    logic [1:0]                          exe_old;
    logic [1:0]                          exe_new;
    logic                                unused_pc_bits;

    function automatic logic [PHT_WIDTH-1:0] pht_index(
        input logic [PC_WIDTH-1:0] pc,
        input logic [HIST_LEN-1:0] h
    );
        return pc[PHT_WIDTH+1:2] ^ PHT_WIDTH'(h);
    endfunction

    assign init_busy = (state == ST_SWEEP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_SWEEP;
            sweep_idx <= '0;
        end else begin
            state <= state_next;
            if (init_busy) begin
                sweep_idx <= sweep_idx + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_SWEEP: if (&sweep_idx) state_next = ST_RUN;
            ST_RUN:   state_next = ST_RUN;
            default:  state_next = ST_SWEEP;
        endcase
    end

    // Walk the fetch group in slot order; history seen by each slot includes every earlier
    // live branch, and the first predicted-taken slot kills everything behind it.
    always_comb begin
        hist      = spec_ghr;
        squash    = 1'b0;
        pred_bit  = 1'b0;
        taken_vec = '0;
        ghr_vec   = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            ghr_vec[k] = hist;
            pred_bit   = 1'b0;
            if (bp.if_valid[k] && bp.if_is_branch[k] && !squash) begin
                pred_bit     = pht[pht_index(bp.if_pc[k], hist)][1] && !init_busy;
                taken_vec[k] = pred_bit;
                hist         = (hist << 1) | HIST_LEN'(pred_bit);
                if (pred_bit) begin
                    squash = 1'b1;
                end
            end
        end
        fetch_ghr = hist;
    end

    assign bp.predict_taken = taken_vec;
    assign bp.predict_ghr   = ghr_vec;
    assign bp.init_busy     = init_busy;

    always_comb begin
        exe_idx = pht_index(bp.exe_pc, bp.exe_ghr);
        exe_old = pht[exe_idx];
        exe_new = exe_old;
        if (bp.exe_taken) begin
            if (exe_old != 2'b11) exe_new = exe_old + 2'b01;
        end else begin
            if (exe_old != 2'b00) exe_new = exe_old - 2'b01;
        end
    end

    // Single PHT write port: the sweep owns it while busy, resolved branches afterwards.
    always_comb begin
        pht_we    = 1'b0;
        pht_waddr = exe_idx;
        pht_wdata = exe_new;
        if (!rst) begin
            if (init_busy) begin
                pht_we    = 1'b1;
                pht_waddr = sweep_idx;
                pht_wdata = INIT_STATE;
            end else if (bp.exe_valid) begin
                pht_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pht_we) begin
            pht[pht_waddr] <= pht_wdata;
        end
    end

    // A misprediction repair rebuilds history from the branch's own snapshot and wins over
    // whatever the fetch group would have shifted in this cycle.
    always_comb begin
        spec_ghr_next = spec_ghr;
        if (!init_busy) begin
            if (bp.exe_valid && bp.exe_mispredict) begin
                spec_ghr_next = (bp.exe_ghr << 1) | HIST_LEN'(bp.exe_taken);
            end else if (!bp.if_stall) begin
                spec_ghr_next = fetch_ghr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            spec_ghr <= '0;
        end else begin
            spec_ghr <= spec_ghr_next;
        end
    end

    assign unused_pc_bits = ^{bp.if_pc, bp.exe_pc};

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Directed bench for gshare_branch_predictor: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_gshare_branch_predictor;

    localparam int PHT_WIDTH = 10;
    localparam int HIST_LEN  = 8;
    localparam int NUM_PORTS = 2;
    localparam int PC_WIDTH  = 32;

    localparam logic [1:0] SEL_TAKEN = 2'd0;
    localparam logic [1:0] SEL_GHR0  = 2'd1;
    localparam logic [1:0] SEL_GHR1  = 2'd2;
    localparam logic [1:0] SEL_BUSY  = 2'd3;

    // Counter walk on pc 0x100: expected slot0 prediction, exe_valid and exe_taken per step
    localparam logic [7:0] A_EXP = 8'b0001_1110;
    localparam logic [7:0] A_EV  = 8'b0111_1111;
    localparam logic [7:0] A_ET  = 8'b0000_0111;

    typedef struct packed {
        logic [31:0]  cyc;
        logic [127:0] name;
        logic [1:0]   sel;
        logic [31:0]  exp;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic [31:0] mon_act;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    gshare_branch_predictor_if #(
        .NUM_PORTS(NUM_PORTS), .PC_WIDTH(PC_WIDTH), .HIST_LEN(HIST_LEN)
    ) bp_if ();

    gshare_branch_predictor #(
        .PHT_WIDTH(PHT_WIDTH), .HIST_LEN(HIST_LEN), .NUM_PORTS(NUM_PORTS),
        .PC_WIDTH(PC_WIDTH), .INIT_STATE(2'b01)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bp(bp_if.slave)
    );

    task automatic apply_stimulus(
        input logic [1:0]  valid,
        input logic [1:0]  br,
        input logic [31:0] pc0,
        input logic [31:0] pc1,
        input logic        stall,
        input logic        ev,
        input logic        et,
        input logic        em,
        input logic [31:0] epc,
        input logic [7:0]  eghr
    );
        @(posedge clk);
        #1;
        rst                   = 1'b0;
        bp_if.if_valid        = valid;
        bp_if.if_is_branch    = br;
        bp_if.if_pc[0]        = pc0;
        bp_if.if_pc[1]        = pc1;
        bp_if.if_stall        = stall;
        bp_if.exe_valid       = ev;
        bp_if.exe_taken       = et;
        bp_if.exe_mispredict  = em;
        bp_if.exe_pc          = epc;
        bp_if.exe_ghr         = eghr;
    endtask

    task automatic idle_cycle();
        apply_stimulus(2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00);
    endtask

    task automatic assert_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        bp_if.if_valid  = '0;
        bp_if.exe_valid = 1'b0;
    endtask

    task automatic check_output(input logic [127:0] name, input logic [1:0] sel, input logic [31:0] exp);
        exp_t e;
        e.cyc  = 32'(cyc);
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && int'(sb[0].cyc) <= cyc) begin
            mon_e = sb.pop_front();
            case (mon_e.sel)
                SEL_TAKEN: mon_act = 32'(bp_if.predict_taken);
                SEL_GHR0:  mon_act = 32'(bp_if.predict_ghr[0]);
                SEL_GHR1:  mon_act = 32'(bp_if.predict_ghr[1]);
                default:   mon_act = 32'(bp_if.init_busy);
            endcase
            checks++;
            if (mon_act !== mon_e.exp) begin
                failures++;
                $display("[TB] FAIL %0s cycle=%0d actual=%h expected=%h", mon_e.name, cyc, mon_act, mon_e.exp);
            end
        end
    end

    initial begin
        bp_if.if_valid       = '0;
        bp_if.if_is_branch   = '0;
        bp_if.if_pc          = '0;
        bp_if.if_stall       = 1'b0;
        bp_if.exe_valid      = 1'b0;
        bp_if.exe_taken      = 1'b0;
        bp_if.exe_mispredict = 1'b0;
        bp_if.exe_pc         = '0;
        bp_if.exe_ghr        = '0;
        repeat (2) @(posedge clk);

        // Partial sweep, then reset again mid-sweep
        for (int i = 0; i < 50; i++) begin
            apply_stimulus(2'b11, 2'b11, 32'(i * 8), 32'(i * 8 + 4), 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00);
            check_output("busy_first", SEL_BUSY, 32'd1);
        end
        assert_reset();

        // Full sweep: busy for exactly 1024 cycles, no predictions, exe traffic dropped
        for (int i = 0; i < 1024; i++) begin
            logic ev, em;
            ev = (i >= 1000 && i < 1010) || (i == 1015);
            em = (i == 1015);
            apply_stimulus(2'b11, 2'b11, 32'(i * 8), 32'(i * 8 + 4), 1'b0,
                           ev, 1'b1, em, 32'h100, em ? 8'h5A : 8'h00);
            check_output("busy_sweep", SEL_BUSY, 32'd1);
            check_output("taken_sweep", SEL_TAKEN, 32'd0);
            if (i == 1020) check_output("ghr_sweep", SEL_GHR0, 32'h00);
        end

        // Saturating counter walk at pc 0x100 with history 0; fetch stalled so history holds
        for (int k = 0; k < 8; k++) begin
            apply_stimulus(2'b01, 2'b01, 32'h100, 32'h0, 1'b1, A_EV[k], A_ET[k], 1'b0, 32'h100, 8'h00);
            check_output("ctr_walk", SEL_TAKEN, {31'd0, A_EXP[k]});
            if (k == 0) check_output("busy_done", SEL_BUSY, 32'd0);
        end
        check_output("ghr_after_walk", SEL_GHR0, 32'h00);

        // History restore to 0x03, then two not-taken branches in one group
        apply_stimulus(2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h800, 8'h01);
        apply_stimulus(2'b11, 2'b11, 32'h2000, 32'h3000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00);
        check_output("ghr_restore03", SEL_GHR0, 32'h03);
        check_output("ghr_slot1_nt", SEL_GHR1, 32'h06);
        check_output("taken_nt_nt", SEL_TAKEN, 32'h0);

        // Repair overrides the accepted fetch group in the same cycle
        apply_stimulus(2'b01, 2'b01, 32'h2000, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h800, 8'h5A);
        check_output("ghr_two_shift", SEL_GHR0, 32'h0C);

        // Stall with live branch slots holds history
        for (int k = 0; k < 5; k++) begin
            apply_stimulus(2'b11, 2'b11, 32'h2000, 32'h3000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00);
            check_output("ghr_repair_stall", SEL_GHR0, 32'hB5);
            check_output("ghr1_stall", SEL_GHR1, 32'h6A);
            check_output("taken_stall", SEL_TAKEN, 32'h0);
        end
        idle_cycle();
        check_output("ghr_after_stall", SEL_GHR0, 32'hB5);

        // Slot0 predicted taken squashes slot1
        apply_stimulus(2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h3FC, 8'h00);
        apply_stimulus(2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h2000, 8'h00);
        check_output("ghr_restore00", SEL_GHR0, 32'h00);
        apply_stimulus(2'b11, 2'b11, 32'h2000, 32'h3000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00);
        check_output("taken_squash", SEL_TAKEN, 32'h1);
        check_output("ghr1_squash", SEL_GHR1, 32'h01);
        idle_cycle();
        check_output("ghr_one_shift", SEL_GHR0, 32'h01);

        // Slot1 predicted taken behind a not-taken slot0
        apply_stimulus(2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h800, 8'h01);
        apply_stimulus(2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h3000, 8'h06);
        check_output("ghr_restore03b", SEL_GHR0, 32'h03);
        apply_stimulus(2'b11, 2'b11, 32'h2000, 32'h3000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00);
        check_output("taken_slot1", SEL_TAKEN, 32'h2);
        check_output("ghr1_slot1", SEL_GHR1, 32'h06);
        idle_cycle();
        check_output("ghr_nt_t", SEL_GHR0, 32'h0D);

        // Mispredict flag without exe_valid is ignored
        apply_stimulus(2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 8'h5A);
        idle_cycle();
        check_output("ghr_no_valid", SEL_GHR0, 32'h0D);

        repeat (3) @(posedge clk);
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL scoreboard_drain actual=%0d pending expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
